// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct constants, FSM and ALU enums, ALU helper for mips_multicycle_core
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
`endif

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_t;

    function automatic logic [31:0] alu(alu_op_t op, logic [31:0] x, logic [31:0] y);
        return op == ALU_SUB ? x - y :
               op == ALU_AND ? x & y :
               op == ALU_OR  ? x | y :
               op == ALU_SLT ? {31'd0, $signed(x) < $signed(y)} :
               op == ALU_LUI ? {y[15:0], 16'h0000} :
                               x + y;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32x32 register file, two async read ports, one sync write port, r0 hardwired to 0
module mips_mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [0:31];

    assign rd1 = ra1 == 5'd0 ? 32'd0 : regs[ra1];
    assign rd2 = ra2 == 5'd0 ? 32'd0 : regs[ra2];

    // clear all registers on reset; writes to r0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core on one unified req/ready memory port (option: MIPS_MC_ILLEGAL_TRAP_EN)
module mips_multicycle_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              instr_retired
);

    state_t      state, state_nx;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] rd1, rd2, sext, zext, alu_y, alu_res;
    alu_op_t     alu_op;
    logic        rf_we;

    wire [5:0]  op    = ir[31:26];
    wire [5:0]  funct = ir[5:0];
    wire [4:0]  rs    = ir[25:21];
    wire [4:0]  rt    = ir[20:16];
    wire [4:0]  rd    = ir[15:11];
    wire [15:0] imm   = ir[15:0];

    wire is_r    = op == OP_RTYPE;
    wire is_addi = op == OP_ADDI;
    wire is_ori  = op == OP_ORI;
    wire is_lui  = op == OP_LUI;
    wire is_lw   = op == OP_LW;
    wire is_sw   = op == OP_SW;
    wire is_beq  = op == OP_BEQ;
    wire is_j    = op == OP_J;
    wire r_ok    = is_r && (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                            funct == F_OR  || funct == F_SLT);
    wire is_mem  = is_lw || is_sw;
    wire wr_reg  = r_ok || is_addi || is_ori || is_lui;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    wire legal   = wr_reg || is_mem || is_beq || is_j;
`endif

    wire pending = state == S_FETCH || state == S_MEM;
    wire hs      = !reset && pending && mem_ready;

    assign sext    = {{16{imm[15]}}, imm};
    assign zext    = {16'h0000, imm};
    assign alu_y   = is_r ? b : (is_ori || is_lui) ? zext : sext;
    assign alu_res = alu(alu_op, a, alu_y);

    mips_mc_regfile u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (rf_we),
        .wa    (is_r ? rd : rt),
        .wd    (is_lw ? mdr : alu_out)
    );

    // ALU operation select from opcode/funct
    always_comb begin
        alu_op = is_r   ? (funct == F_SUB ? ALU_SUB :
                           funct == F_AND ? ALU_AND :
                           funct == F_OR  ? ALU_OR  :
                           funct == F_SLT ? ALU_SLT : ALU_ADD) :
                 is_ori ? ALU_OR :
                 is_lui ? ALU_LUI : ALU_ADD;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // FSM next state; branch, jump and unsupported ops finish in EXEC
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = hs ? S_DECODE : S_FETCH;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
`else
            S_DECODE: state_nx = S_EXEC;
`endif
            S_EXEC:   state_nx = is_mem ? S_MEM : wr_reg ? S_WB : S_FETCH;
            S_MEM:    state_nx = hs ? (is_sw ? S_FETCH : S_WB) : S_MEM;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = state;
        endcase
    end

    // FSM outputs; everything visible is forced idle while reset is high
    always_comb begin
        mem_req       = !reset && pending;
        mem_we        = !reset && state == S_MEM && is_sw;
        mem_addr      = state == S_MEM ? {alu_out[ADDR_W-1:2], 2'b00} : {pc[ADDR_W-1:2], 2'b00};
        mem_wdata     = b;
        rf_we         = !reset && state == S_WB;
        instr_retired = !reset && ((state == S_EXEC && !is_mem && !wr_reg) ||
                                   (state == S_MEM && hs && is_sw) || state == S_WB);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        halted        = !reset && state == S_HALT;
`else
        halted        = 1'b0;
`endif
    end

    // datapath registers: pc, IR, operand latches, ALU result, memory data
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if (state == S_FETCH && hs) begin
                ir <= mem_rdata;
                pc <= pc + 32'd4;
            end
            if (state == S_DECODE) begin
                a <= rd1;
                b <= rd2;
            end
            if (state == S_EXEC) begin
                alu_out <= alu_res;
                if (is_beq && a == b) pc <= pc + (sext << 2);
                if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
            end
            if (state == S_MEM && hs && is_lw) mdr <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed program tests with hand-computed results for mips_multicycle_core
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted, instr_retired;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc;
    logic        stab;

    mips_multicycle_core dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .halted        (halted),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_ret", {31'd0, instr_retired}, 32'd0);
        reset = 1'b0;
    endtask

    // run one instruction from its fetch cycle; stall holds mem_ready low for that many MEM cycles
    task automatic run_instr(input int stall, output int cycles, output logic stable);
        logic [65:0] snap;
        logic        done;
        cycles = 0;
        stable = 1'b1;
        done   = 1'b0;
        snap   = '0;
        for (int n = 1; n <= 40 && !done; n++) begin
            mem_ready = !(n >= 4 && n < 4 + stall);
            #1;
            if (n == 4) snap = {mem_req, mem_we, mem_addr, mem_wdata};
            if (n > 4 && n <= 4 + stall && {mem_req, mem_we, mem_addr, mem_wdata} != snap) stable = 1'b0;
            if (mem_req && mem_ready && mem_we) mem[mem_addr[7:2]] = mem_wdata;
            if (instr_retired) begin
                cycles = n;
                done = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        mem_ready = 1'b1;
        // program A: ALU ops, stalled sw/lw, unsupported opcode
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
        mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[4] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
        mem[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        mem[6] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        mem[7] = {6'h3F, 26'h0};
        do_reset();
        #1;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        run_instr(0, cyc, stab);
        check("addi_lat", cyc, 4);
        check("r1", dut.u_rf.regs[1], 32'd5);
        run_instr(0, cyc, stab);
        check("r2", dut.u_rf.regs[2], 32'hFFFF_FFFD);
        run_instr(0, cyc, stab);
        check("sub_r3", dut.u_rf.regs[3], 32'd8);
        run_instr(0, cyc, stab);
        check("slt_r4", dut.u_rf.regs[4], 32'd1);
        run_instr(0, cyc, stab);
        check("add_r0_lat", cyc, 4);
        check("r0", dut.u_rf.regs[0], 32'd0);
        run_instr(3, cyc, stab);
        check("sw_lat", cyc, 7);
        check("sw_stable", {31'd0, stab}, 32'd1);
        check("sw_mem8", mem[2], 32'd5);
        run_instr(3, cyc, stab);
        check("lw_lat", cyc, 8);
        check("lw_stable", {31'd0, stab}, 32'd1);
        check("lw_r5", dut.u_rf.regs[5], 32'd5);
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        begin
            int rets = 0;
            int reqs = 0;
            for (int n = 1; n <= 10; n++) begin
                mem_ready = 1'b1;
                #1;
                if (instr_retired) rets++;
                if (n >= 3 && mem_req) reqs++;
                @(negedge clk);
            end
            check("trap_halted", {31'd0, halted}, 32'd1);
            check("trap_no_ret", rets, 0);
            check("trap_no_req", reqs, 0);
            check("trap_pc", dut.pc, 32'h20);
        end
`else
        run_instr(0, cyc, stab);
        check("ill_lat", cyc, 3);
        check("ill_halted", {31'd0, halted}, 32'd0);
        check("ill_next", mem_addr, 32'h20);
`endif
        check("ill_r1", dut.u_rf.regs[1], 32'd5);
        check("ill_r3", dut.u_rf.regs[3], 32'd8);
        check("ill_r5", dut.u_rf.regs[5], 32'd5);
        check("ill_mem8", mem[2], 32'd5);

        // program B: ori/lui/and, beq taken and not taken, j
        reset = 1'b1;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h0D, 5'd0, 5'd6, 16'h8001);
        mem[2] = enc_i(6'h0F, 5'd0, 5'd7, 16'h1234);
        mem[3] = enc_r(5'd6, 5'd1, 5'd8, 6'h24);
        mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        mem[5] = {6'h02, 26'h40};
        do_reset();
        for (int k = 0; k < 4; k++) run_instr(0, cyc, stab);
        check("ori_r6", dut.u_rf.regs[6], 32'h0000_8001);
        check("lui_r7", dut.u_rf.regs[7], 32'h1234_0000);
        check("and_r8", dut.u_rf.regs[8], 32'd1);
        run_instr(0, cyc, stab);
        check("beq_lat", cyc, 3);
        check("beq_taken", mem_addr, 32'h10);
        mem[4] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
        run_instr(0, cyc, stab);
        check("beq_not_taken", mem_addr, 32'h14);
        run_instr(0, cyc, stab);
        check("j_lat", cyc, 3);
        check("j_target", mem_addr, 32'h100);

        // program C: reset during a stalled store
        reset = 1'b1;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd12);
        mem[3] = 32'hDEAD_BEEF;
        do_reset();
        run_instr(0, cyc, stab);
        check("c_r1", dut.u_rf.regs[1], 32'd7);
        for (int n = 1; n <= 3; n++) begin
            mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        check("c_sw_pending", {30'd0, mem_req, mem_we}, 32'd3);
        check("c_sw_addr", mem_addr, 32'd12);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("c_rst_req", {30'd0, mem_req, mem_we}, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("c_refetch_req", {31'd0, mem_req}, 32'd1);
        check("c_refetch_addr", mem_addr, 32'h0);
        check("c_no_write", mem[3], 32'hDEAD_BEEF);
        check("c_r1_clr", dut.u_rf.regs[1], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
